// File: rtl/psum_drain_pkg.sv
// Shared definitions for the pStore read side: FSM encoding, layer-derived
// defaults and the node-index width helper.
package psum_drain_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam int RELU_NODES            = 2;
  localparam int LAYER_1_OUT_BIT_WIDTH = 8;
  localparam int OUT_W_DEF             = 4;

  // A single node still needs a 1-bit index port.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_drain_relu_saturate.sv
// Combinational activation: arithmetic rescale, ReLU, then clamp to the
// unsigned OUT_W range.
module relu_saturate #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  sumIn,
  output logic        [OUT_W-1:0] act
);

  localparam int MAXV = (1 << OUT_W) - 1;

  logic signed [IN_W-1:0] shifted;
  int                     s;

  always_comb begin
    shifted = sumIn >>> SHIFT;
    s       = int'(shifted);
    if (s < 0)
      act = '0;
    else if (s > MAXV)
      act = '1;
    else
      act = s[OUT_W-1:0];
  end

endmodule

// File: rtl/psum_drain.sv
// Captures all node sums from pStore on sumValid, clears pStore, and streams
// one ReLU/saturated activation per accepted beat downstream.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int NODES = RELU_NODES,
  parameter int IN_W  = LAYER_1_OUT_BIT_WIDTH,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [NODES*IN_W-1:0]        sumIn,
  input  logic                         sumValid,
  output logic                         sumReady,
  output logic                         storeClr,
  output logic [OUT_W-1:0]             dataOut,
  output logic [idxWidth(NODES)-1:0]   nodeIdx,
  output logic                         outValid,
  input  logic                         outReady,
  output logic                         lastOut,
  output logic                         overrun,
  output state_t                       dbgState
);

  localparam int IDX_W = idxWidth(NODES);

  // Handshake: a beat transfers on a rising edge where outValid && outReady;
  // outValid never drops and dataOut/nodeIdx never change until that happens.
  // A capture happens on a rising edge where sumValid && sumReady.

  state_t                  state, nextState;
  logic [NODES*IN_W-1:0]   capReg;
  logic [IN_W-1:0]         selSum;
  logic [OUT_W-1:0]        act;
  logic                    isLast;
  logic                    beatDone;
  logic                    capture;

  assign dbgState = state;

  always_comb begin
    selSum = '0;
    for (int k = 0; k < NODES; k++)
      if (nodeIdx == IDX_W'(k))
        selSum = capReg[k*IN_W +: IN_W];
  end

  relu_saturate #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_relu (
    .sumIn (selSum),
    .act   (act)
  );

  always_comb begin
    sumReady  = (state == ST_IDLE);
    outValid  = (state == ST_STREAM);
    isLast    = (nodeIdx == IDX_W'(NODES - 1));
    lastOut   = outValid && isLast;
    dataOut   = outValid ? act : '0;
    capture   = sumReady && sumValid;
    beatDone  = outValid && outReady;
    nextState = state;
    case (state)
      ST_IDLE:   if (sumValid) nextState = ST_STREAM;
      ST_STREAM: if (beatDone && isLast) nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      capReg   <= '0;
      nodeIdx  <= '0;
      storeClr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= nextState;
      storeClr <= capture;
      if (capture) begin
        capReg  <= sumIn;
        nodeIdx <= '0;
      end else if (beatDone) begin
        nodeIdx <= isLast ? '0 : nodeIdx + IDX_W'(1);
      end
      // Includes the final-beat cycle: the sums arrive before we can take them.
      if (sumValid && !sumReady)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Directed plus randomized bench for psum_drain; two instances (SHIFT 0 and 2)
// run in lockstep against an arithmetic activation model.
module tb_psum_drain;
  import psum_drain_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] sumIn;
  logic        sumValid;
  logic        outReady;

  logic        sumReadyA, storeClrA, outValidA, lastOutA, overrunA;
  logic [3:0]  dataOutA;
  logic [0:0]  nodeIdxA;
  state_t      dbgStateA;
  logic        sumReadyB, storeClrB, outValidB, lastOutB, overrunB;
  logic [3:0]  dataOutB;
  logic [0:0]  nodeIdxB;
  state_t      dbgStateB;

  int checks = 0;
  int errors = 0;
  bit ovrExp = 1'b0;

  psum_drain #(.NODES(2), .IN_W(8), .OUT_W(4), .SHIFT(0)) dut (
    .clk(clk), .clr(clr), .sumIn(sumIn), .sumValid(sumValid),
    .sumReady(sumReadyA), .storeClr(storeClrA), .dataOut(dataOutA),
    .nodeIdx(nodeIdxA), .outValid(outValidA), .outReady(outReady),
    .lastOut(lastOutA), .overrun(overrunA), .dbgState(dbgStateA)
  );

  psum_drain #(.NODES(2), .IN_W(8), .OUT_W(4), .SHIFT(2)) dut2 (
    .clk(clk), .clr(clr), .sumIn(sumIn), .sumValid(sumValid),
    .sumReady(sumReadyB), .storeClr(storeClrB), .dataOut(dataOutB),
    .nodeIdx(nodeIdxB), .outValid(outValidB), .outReady(outReady),
    .lastOut(lastOutB), .overrun(overrunB), .dbgState(dbgStateB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference activation: plain integer arithmetic on the signed sum.
  function automatic int actModel(input logic [7:0] s, input int sh);
    int v;
    v = int'($signed(s));
    v = v >>> sh;
    if (v < 0) return 0;
    if (v > 15) return 15;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_sumReadyA"}, sumReadyA, 1);
    chk({tag, "_sumReadyB"}, sumReadyB, 1);
    chk({tag, "_outValidA"}, outValidA, 0);
    chk({tag, "_outValidB"}, outValidB, 0);
    chk({tag, "_storeClrA"}, storeClrA, 0);
    chk({tag, "_storeClrB"}, storeClrB, 0);
    chk({tag, "_dataOutA"},  dataOutA, 0);
    chk({tag, "_nodeIdxA"},  nodeIdxA, 0);
    chk({tag, "_lastOutA"},  lastOutA, 0);
    chk({tag, "_overrunA"},  overrunA, 0);
    chk({tag, "_overrunB"},  overrunB, 0);
    chk({tag, "_stateA"},    dbgStateA, ST_IDLE);
  endtask

  // Capture sums, then drain both beats. stall0 holds beat 0; randStall adds
  // random backpressure; inject: 1 = sumValid in first stream cycle,
  // 2 = sumValid in the cycle the final beat is accepted.
  task automatic runStream(input logic [15:0] sums, input int stall0,
                           input bit randStall, input int inject, input string tag);
    logic [3:0] expA_q[$];
    logic [3:0] expB_q[$];
    int         stalls;
    for (int k = 0; k < 2; k++) begin
      expA_q.push_back(4'(actModel(sums[k*8 +: 8], 0)));
      expB_q.push_back(4'(actModel(sums[k*8 +: 8], 2)));
    end
    sumIn    = sums;
    sumValid = 1'b1;
    outReady = 1'b0;
    tick();
    sumValid = 1'b0;
    sumIn    = 16'($urandom);
    chk({tag, "_storeClrA"}, storeClrA, 1);
    chk({tag, "_storeClrB"}, storeClrB, 1);
    chk({tag, "_stateA"},    dbgStateA, ST_STREAM);
    for (int k = 0; k < 2; k++) begin
      stalls = (k == 0) ? stall0 : 0;
      if (randStall) stalls += $urandom_range(0, 2);
      for (int c = 0; c <= stalls; c++) begin
        outReady = (c == stalls);
        sumValid = (inject == 1 && k == 0 && c == 0) ||
                   (inject == 2 && k == 1 && c == stalls);
        chk({tag, "_outValid"}, outValidA, 1);
        chk({tag, "_sumReady"}, sumReadyA, 0);
        chk({tag, "_nodeIdxA"}, nodeIdxA, k);
        chk({tag, "_nodeIdxB"}, nodeIdxB, k);
        chk({tag, "_dataOutA"}, dataOutA, expA_q[0]);
        chk({tag, "_dataOutB"}, dataOutB, expB_q[0]);
        chk({tag, "_lastOutA"}, lastOutA, (k == 1));
        chk({tag, "_lastOutB"}, lastOutB, (k == 1));
        chk({tag, "_overrunA"}, overrunA, ovrExp);
        if (k > 0 || c > 0) chk({tag, "_storeClrHold"}, storeClrA, 0);
        tick();
        if (sumValid) ovrExp = 1'b1;
        sumValid = 1'b0;
      end
      void'(expA_q.pop_front());
      void'(expB_q.pop_front());
    end
    outReady = 1'b0;
    chk({tag, "_endOutValid"}, outValidA, 0);
    chk({tag, "_endSumReadyA"}, sumReadyA, 1);
    chk({tag, "_endSumReadyB"}, sumReadyB, 1);
    chk({tag, "_endStoreClr"}, storeClrA, 0);
    chk({tag, "_endOverrunA"}, overrunA, ovrExp);
    chk({tag, "_endOverrunB"}, overrunB, ovrExp);
    chk({tag, "_endQueue"}, expA_q.size(), 0);
  endtask

  initial begin
    clr      = 1'b1;
    sumIn    = '0;
    sumValid = 1'b0;
    outReady = 1'b0;
    #2;
    checkReset("reset");
    tick();
    tick();
    clr = 1'b0;
    tick();
    checkReset("postReset");

    runStream({8'hFA, 8'h05}, 0, 1'b0, 0, "basic");
    tick();
    runStream({8'h7F, 8'h40}, 0, 1'b0, 0, "sat");
    tick();
    runStream({8'h20, 8'hF8}, 0, 1'b0, 0, "shift");
    tick();
    runStream({8'hFA, 8'h05}, 3, 1'b0, 0, "bp");
    // Back-to-back: the next capture lands on the first IDLE cycle.
    runStream({8'h03, 8'h09}, 0, 1'b0, 0, "b2b");
    runStream({8'h80, 8'h0F}, 0, 1'b0, 0, "edge");

    for (int i = 0; i < 12; i++) begin
      runStream(16'($urandom), 0, 1'b1, 0, "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    runStream({8'hFA, 8'h05}, 1, 1'b0, 1, "ovrFirst");
    tick();
    runStream({8'h11, 8'h22}, 0, 1'b1, 0, "ovrSticky");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ovrExp = 1'b0;
    tick();
    checkReset("ovrCleared");

    runStream({8'h01, 8'h3C}, 0, 1'b0, 2, "ovrReturn");
    tick();
    chk("ovrReturn_noCapture", outValidA, 0);
    chk("ovrReturn_noStoreClr", storeClrA, 0);

    // Asynchronous clear in the middle of a stream.
    sumIn    = 16'h0505;
    sumValid = 1'b1;
    tick();
    sumValid = 1'b0;
    chk("midClr_streaming", outValidA, 1);
    clr    = 1'b1;
    ovrExp = 1'b0;
    #1;
    checkReset("midClr");
    tick();
    clr = 1'b0;
    tick();
    runStream({8'h07, 8'hFF}, 0, 1'b1, 0, "afterClr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
